// File: rtl/regfile_pkg.sv
// Shared constants for the multiport register file and its busy-bit scoreboard.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_NUM_RD = 2;
    localparam int unsigned DEF_NUM_WR = 2;

    // Hardwired-zero register: reads 0, drops writes, never goes busy.
    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits (pending producer) and a registered busy-register count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  IssueEn,
    input  logic [ADDR_W-1:0]     IssueReg,
    input  logic [2**ADDR_W-1:0]  wr_hit,
    output logic [2**ADDR_W-1:0]  busy,
    output logic [ADDR_W:0]       BusyCount
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DEPTH-1:0] busy_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Writes retire producers; a same-cycle issue re-acquires, so set wins.
    always_comb begin
        busy_nxt = busy & ~wr_hit;
        if (IssueEn && (IssueReg != ADDR_W'(ZERO_REG))) begin
            busy_nxt[IssueReg] = 1'b1;
        end
        busy_nxt[ZERO_REG] = 1'b0;

        cnt_nxt = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            busy      <= '0;
            BusyCount <= '0;
        end else begin
            busy      <= busy_nxt;
            BusyCount <= cnt_nxt;
        end
    end

endmodule

// File: rtl/multiport_regfile.sv
// Multiport register file with highest-port-wins write merge, optional
// write-to-read forwarding, and a busy-bit scoreboard for pending producers.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned NUM_RD = DEF_NUM_RD,
    parameter int unsigned NUM_WR = DEF_NUM_WR,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_RD*ADDR_W-1:0]   ReadReg,
    output logic [NUM_RD*DATA_W-1:0]   ReadData,
    output logic [NUM_RD-1:0]          ReadBusy,
    input  logic [NUM_WR-1:0]          WriteEn,
    input  logic [NUM_WR*ADDR_W-1:0]   WriteReg,
    input  logic [NUM_WR*DATA_W-1:0]   WriteData,
    input  logic                       IssueEn,
    input  logic [ADDR_W-1:0]          IssueReg,
    output logic [ADDR_W:0]            BusyCount
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs   [DEPTH];
    logic [DATA_W-1:0] wr_val [DEPTH];
    logic [DEPTH-1:0]  wr_hit;
    logic [DEPTH-1:0]  busy;
    logic [ADDR_W-1:0] wa;
    logic [ADDR_W-1:0] ra;

    // Write merge: later (higher-index) ports overwrite earlier ones. Writes
    // during reset are dropped, so they neither update storage nor forward.
    always_comb begin
        wr_hit = '0;
        wa     = '0;
        for (int unsigned r = 0; r < DEPTH; r++) begin
            wr_val[r] = '0;
        end
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            wa = WriteReg[i*ADDR_W +: ADDR_W];
            if (!Reset && WriteEn[i] && (wa != ADDR_W'(ZERO_REG))) begin
                wr_hit[wa] = 1'b1;
                wr_val[wa] = WriteData[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < DEPTH; r++) begin
                if (wr_hit[r]) begin
                    regs[r] <= wr_val[r];
                end
            end
        end
    end

    // Read muxes; with forwarding, an in-flight write also hides the busy bit.
    always_comb begin
        ReadData = '0;
        ReadBusy = '0;
        ra       = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = ReadReg[k*ADDR_W +: ADDR_W];
            if (BYPASS && wr_hit[ra]) begin
                ReadData[k*DATA_W +: DATA_W] = wr_val[ra];
            end else if (ra != ADDR_W'(ZERO_REG)) begin
                ReadData[k*DATA_W +: DATA_W] = regs[ra];
            end
            ReadBusy[k] = busy[ra] & ~(BYPASS & wr_hit[ra]);
        end
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .Clock     (Clock),
        .Reset     (Reset),
        .IssueEn   (IssueEn),
        .IssueReg  (IssueReg),
        .wr_hit    (wr_hit),
        .busy      (busy),
        .BusyCount (BusyCount)
    );

endmodule

// File: tb/tb_multiport_regfile.sv
// Bench: forwarding and non-forwarding instances share stimulus; expectations
// are queued by the driver and compared by a negedge monitor.
module tb_multiport_regfile;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;

    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_CNT  = 2;

    logic              Clock = 1'b0;
    logic              Reset = 1'b1;
    logic [NR*AW-1:0]  ReadReg = '0;
    logic [NW-1:0]     WriteEn = '0;
    logic [NW*AW-1:0]  WriteReg = '0;
    logic [NW*DW-1:0]  WriteData = '0;
    logic              IssueEn = 1'b0;
    logic [AW-1:0]     IssueReg = '0;

    logic [NR*DW-1:0]  rd_data_b, rd_data_n;
    logic [NR-1:0]     rd_busy_b, rd_busy_n;
    logic [AW:0]       cnt_b, cnt_n;

    typedef struct {
        string       name;
        int          dut_sel;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 Clock = ~Clock;

    multiport_regfile #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b1)
    ) dut (
        .Clock(Clock), .Reset(Reset), .ReadReg(ReadReg), .ReadData(rd_data_b),
        .ReadBusy(rd_busy_b), .WriteEn(WriteEn), .WriteReg(WriteReg),
        .WriteData(WriteData), .IssueEn(IssueEn), .IssueReg(IssueReg),
        .BusyCount(cnt_b)
    );

    multiport_regfile #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1'b0)
    ) dut_nb (
        .Clock(Clock), .Reset(Reset), .ReadReg(ReadReg), .ReadData(rd_data_n),
        .ReadBusy(rd_busy_n), .WriteEn(WriteEn), .WriteReg(WriteReg),
        .WriteData(WriteData), .IssueEn(IssueEn), .IssueReg(IssueReg),
        .BusyCount(cnt_n)
    );

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge Clock) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            act = '0;
            case (e.kind)
                K_DATA:  act = (e.dut_sel == 0) ? rd_data_b[e.port*DW +: DW]
                                                : rd_data_n[e.port*DW +: DW];
                K_BUSY:  act = 32'((e.dut_sel == 0) ? rd_busy_b[e.port] : rd_busy_n[e.port]);
                default: act = 32'((e.dut_sel == 0) ? cnt_b : cnt_n);
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s dut=%0d port=%0d actual=%0h expected=%0h",
                         e.name, e.dut_sel, e.port, act, e.exp);
            end
        end
    end

    task automatic push(input string n, input int sel, input int kind, input int port,
                        input logic [31:0] v);
        exp_t e;
        e.name = n; e.dut_sel = sel; e.kind = kind; e.port = port; e.exp = v;
        q.push_back(e);
    endtask

    task automatic push2(input string n, input int kind, input int port, input logic [31:0] v);
        push(n, 0, kind, port, v);
        push(n, 1, kind, port, v);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        ReadReg[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        WriteEn[p] = 1'b1;
        WriteReg[p*AW +: AW] = a;
        WriteData[p*DW +: DW] = d;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        IssueEn = 1'b1;
        IssueReg = a;
    endtask

    task automatic idle();
        WriteEn = '0;
        IssueEn = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout no_finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick();
        set_rd(0, 5'd5); set_rd(1, 5'd31);
        push2("rst_cnt", K_CNT, 0, 32'd0);
        push2("rst_rd0", K_DATA, 0, 32'd0);
        push2("rst_rd1", K_DATA, 1, 32'd0);
        tick();
        Reset = 1'b0;

        // Write reg 5 via port 0; forwarding visible only on the bypass instance
        set_wr(0, 5'd5, 32'hDEADBEEF);
        set_rd(0, 5'd5); set_rd(1, 5'd5);
        push("byp_r5", 0, K_DATA, 0, 32'hDEADBEEF);
        push("byp_r5", 1, K_DATA, 0, 32'h0);
        tick();
        idle();
        push2("wr_r5_p0", K_DATA, 0, 32'hDEADBEEF);
        push2("wr_r5_p1", K_DATA, 1, 32'hDEADBEEF);
        tick();

        // Both ports write reg 9; port 1 wins
        set_wr(0, 5'd9, 32'h11); set_wr(1, 5'd9, 32'h22);
        set_rd(0, 5'd9); set_rd(1, 5'd9);
        push("prio_byp", 0, K_DATA, 1, 32'h22);
        push("prio_byp", 1, K_DATA, 1, 32'h0);
        tick();
        idle();
        push2("prio_r9", K_DATA, 0, 32'h22);
        tick();

        // Same-cycle read of reg 3 during a write
        set_wr(0, 5'd3, 32'hAAAA);
        tick();
        idle();
        set_wr(1, 5'd3, 32'h1234);
        set_rd(0, 5'd3);
        push("rw_r3", 0, K_DATA, 0, 32'h1234);
        push("rw_r3", 1, K_DATA, 0, 32'hAAAA);
        tick();
        idle();
        push2("after_r3", K_DATA, 0, 32'h1234);
        tick();

        // Register 0: write and issue both ignored
        set_wr(0, 5'd0, 32'hFFFFFFFF);
        issue(5'd0);
        set_rd(0, 5'd0);
        push2("r0_same", K_DATA, 0, 32'h0);
        push2("r0_busy_same", K_BUSY, 0, 32'd0);
        tick();
        idle();
        push2("r0_rd", K_DATA, 0, 32'h0);
        push2("r0_busy", K_BUSY, 0, 32'd0);
        push2("r0_cnt", K_CNT, 0, 32'd0);
        tick();

        // Issue 7 then 8
        issue(5'd7);
        tick();
        idle();
        push2("cnt_one", K_CNT, 0, 32'd1);
        issue(5'd8);
        tick();
        idle();
        set_rd(0, 5'd7); set_rd(1, 5'd8);
        push2("cnt_two", K_CNT, 0, 32'd2);
        push2("busy_r7", K_BUSY, 0, 32'd1);
        push2("busy_r8", K_BUSY, 1, 32'd1);

        // Re-issue a busy register and write a non-busy one: count unchanged
        issue(5'd7);
        set_wr(1, 5'd5, 32'h55);
        tick();
        idle();
        set_rd(1, 5'd5);
        push2("reissue_cnt", K_CNT, 0, 32'd2);
        push2("r5_nonbusy", K_BUSY, 1, 32'd0);
        push2("r5_val", K_DATA, 1, 32'h55);
        tick();

        // Write and issue reg 7 together: set wins
        set_wr(0, 5'd7, 32'h77);
        issue(5'd7);
        set_rd(0, 5'd7);
        push("wi_busy_same", 0, K_BUSY, 0, 32'd0);
        push("wi_busy_same", 1, K_BUSY, 0, 32'd1);
        push("wi_data_same", 0, K_DATA, 0, 32'h77);
        push("wi_data_same", 1, K_DATA, 0, 32'h0);
        tick();
        idle();
        push2("wi_cnt", K_CNT, 0, 32'd2);
        push2("wi_busy_r7", K_BUSY, 0, 32'd1);
        push2("wi_data_r7", K_DATA, 0, 32'h77);
        tick();

        // Write reg 8 clears its busy bit
        set_wr(1, 5'd8, 32'h88);
        set_rd(1, 5'd8);
        push("w8_busy_same", 0, K_BUSY, 1, 32'd0);
        push("w8_busy_same", 1, K_BUSY, 1, 32'd1);
        tick();
        idle();
        push2("w8_cnt", K_CNT, 0, 32'd1);
        push2("w8_busy", K_BUSY, 1, 32'd0);
        push2("w8_data", K_DATA, 1, 32'h88);
        tick();

        // Reset with concurrent write and issue to reg 10
        Reset = 1'b1;
        set_wr(0, 5'd10, 32'hA5A5);
        issue(5'd10);
        tick();
        idle();
        set_rd(0, 5'd5); set_rd(1, 5'd9);
        push2("rst2_r5", K_DATA, 0, 32'h0);
        push2("rst2_r9", K_DATA, 1, 32'h0);
        push2("rst2_cnt", K_CNT, 0, 32'd0);
        tick();
        Reset = 1'b0;
        set_rd(0, 5'd10); set_rd(1, 5'd7);
        push2("lost_r10", K_DATA, 0, 32'h0);
        push2("lost_busy10", K_BUSY, 0, 32'd0);
        push2("rst2_busy7", K_BUSY, 1, 32'd0);
        push2("lost_cnt", K_CNT, 0, 32'd0);
        tick();
        tick();

        // Direct final-state checks on both instances
        checks++;
        if (rd_data_b !== rd_data_n) begin
            errors++;
            $display("FAIL final_data_match byp=%0h nobyp=%0h", rd_data_b, rd_data_n);
        end
        checks++;
        if (rd_data_b[0*DW +: DW] !== 32'h0) begin
            errors++;
            $display("FAIL final_r10 actual=%0h expected=0", rd_data_b[0*DW +: DW]);
        end
        checks++;
        if (rd_busy_b !== 2'b00) begin
            errors++;
            $display("FAIL final_busy_b actual=%0h expected=0", rd_busy_b);
        end
        checks++;
        if (rd_busy_n !== 2'b00) begin
            errors++;
            $display("FAIL final_busy_n actual=%0h expected=0", rd_busy_n);
        end
        checks++;
        if (cnt_b !== 6'd0) begin
            errors++;
            $display("FAIL final_cnt_b actual=%0h expected=0", cnt_b);
        end
        checks++;
        if (cnt_n !== 6'd0) begin
            errors++;
            $display("FAIL final_cnt_n actual=%0h expected=0", cnt_n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data word width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_RD, default 2, read port count.
REQ-004 The block SHALL have parameter NUM_WR, default 2, write port count.
REQ-005 The block SHALL have parameter BYPASS, default 1, write-to-read forwarding enable.
REQ-006 The block SHALL have these ports:
- Clock  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- ReadReg  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
- ReadData  out  NUM_RD*DATA_W  read data, same packing.
- ReadBusy  out  NUM_RD  addressed register awaits a pending write.
- WriteEn  in  NUM_WR  per-port write strobe.
- WriteReg  in  NUM_WR*ADDR_W  write addresses.
- WriteData  in  NUM_WR*DATA_W  write data.
- IssueEn  in  1  mark IssueReg busy.
- IssueReg  in  ADDR_W  register acquiring a pending producer.
- BusyCount  out  ADDR_W+1  number of busy registers.

Function
REQ-007 Register 0 SHALL read as zero, ignore writes, and never become busy.
REQ-008 A write with WriteEn[i]=1 and WriteReg!=0 SHALL update the register at the rising edge.
REQ-009 If several write ports target the same register in one cycle, the highest-index port SHALL win.
REQ-010 Reads SHALL be combinational: zero cycles of latency from ReadReg to ReadData.
REQ-011 With BYPASS=1, a read of a register being written in the same cycle SHALL return the winning WriteData.
REQ-012 With BYPASS=0, such a read SHALL return the stored value from before the edge.
REQ-013 The block SHALL hold one busy bit per register.
REQ-014 IssueEn=1 with IssueReg!=0 SHALL set the busy bit at the edge.
REQ-015 Any write to a register SHALL clear its busy bit at the edge.
REQ-016 If an issue and a write target the same register in one cycle, set SHALL win and the bit SHALL stay 1.
REQ-017 With BYPASS=1, ReadBusy[k] SHALL equal the busy bit AND NOT a same-cycle write to that register.
REQ-018 With BYPASS=0, ReadBusy[k] SHALL equal the busy bit.
REQ-019 BusyCount SHALL be a registered count equal to the popcount of the busy bits after each edge.
REQ-020 BusyCount SHALL never exceed 2**ADDR_W-1.
REQ-021 Issuing an already-busy register, or writing a non-busy register, SHALL leave BusyCount unchanged.

Reset
REQ-022 While Reset=1 at an edge, all registers, all busy bits and BusyCount SHALL become 0.
REQ-023 While Reset=1, writes and issues SHALL be ignored.
REQ-024 A write and an issue concurrent with Reset SHALL both be lost.
REQ-025 Combinational outputs SHALL reflect the cleared state from the cycle after the reset edge.

Structure
REQ-026 Package regfile_pkg SHALL hold the default DATA_W, ADDR_W, NUM_RD and NUM_WR constants.
REQ-027 Package regfile_pkg SHALL hold the zero-register index constant.
REQ-028 The busy bits and BusyCount SHALL live in one sub-module, regfile_scoreboard.
REQ-029 Storage, the write-priority merge and the read/bypass muxes SHALL be in multiport_regfile.

Verification
REQ-030 Reset, then write 0xDEADBEEF to reg 5 via port 0 -> next cycle ReadReg=5 returns 0xDEADBEEF on every read port.
REQ-031 Same cycle: port0 writes 0x11 and port1 writes 0x22 to reg 9 -> reg 9 holds 0x22.
REQ-032 BYPASS=1: write 0x1234 to reg 3 while reading reg 3 -> ReadData=0x1234 in that same cycle.
REQ-033 BYPASS=0, same stimulus as REQ-032 -> ReadData shows the old value that cycle.
REQ-034 Write 0xFFFFFFFF to reg 0 and issue reg 0 -> reads 0, ReadBusy=0, BusyCount=0.
REQ-035 Issue reg 7, then reg 8 -> BusyCount=2 and ReadBusy=1 for reg 7.
REQ-036 Then write reg 7 together with issue reg 7 -> reg 7 stays busy and BusyCount stays 2.
REQ-037 Then assert Reset -> all reads 0 and BusyCount=0.
